// File: rtl/modred_sched_if.sv
// Request/response bundle for modred_sched: N_REQ valid/ready operand lanes in,
// one backpressured, requester-tagged residue out, plus pipeline occupancy.
interface modred_sched_if #(
  parameter int Q     = 12289,
  parameter int N_REQ = 4
);
  localparam int K   = $clog2(Q);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*2*K-1:0] req_x;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [K-1:0]         rsp_y;
  logic [IDW-1:0]       rsp_id;
  logic [1:0]           occupancy;

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id, occupancy
  );

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id, occupancy
  );
endinterface

// File: rtl/modred_sched.sv
// Round-robin share of a 3-stage Barrett reducer (x mod Q); one grant per cycle, result 3 stages after grant.
// A held response (rsp_valid & ~rsp_ready) freezes every stage and blocks all new grants.
module modred_sched #(
  parameter int Q     = 12289,
  parameter int N_REQ = 4
) (
  input  logic           clk,
  input  logic           rst,
  modred_sched_if.slave  bus
);
  localparam int K   = $clog2(Q);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int XW  = 2 * K;
  localparam int RW  = K + 1;
  localparam int PW  = XW + K + 1;
  localparam int QW  = K + 1;
  localparam int TW  = K + 2;

  // R < 2^(K+1) because Q > 2^(K-1)
  localparam logic [RW-1:0]  R_C      = RW'((64'd1 << XW) / 64'(Q));
  localparam logic [TW-1:0]  Q_T      = TW'(Q);
  localparam logic [XW:0]    Q_X      = (XW+1)'(Q);
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  logic [IDW-1:0]   last;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [N_REQ-1:0] grant;
  logic             stall;
  logic             accept;
  logic [XW-1:0]    sel_x;

  logic             s1_vld;
  logic [XW-1:0]    s1_x;
  logic [IDW-1:0]   s1_id;
  logic             s2_vld;
  logic [XW-1:0]    s2_x;
  logic [QW-1:0]    s2_qhat;
  logic [IDW-1:0]   s2_id;
  logic             s3_vld;
  logic [K-1:0]     s3_y;
  logic [IDW-1:0]   s3_id;

  logic [QW-1:0]    qhat_d;
  logic [XW:0]      qq;
  logic [TW-1:0]    t0;
  logic [TW-1:0]    t1;
  logic [K-1:0]     y_d;

  // Search last+1, last+2, ... wrapping; first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDW'((int'(last) + off) % N_REQ);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant  = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  assign stall  = s3_vld & ~bus.rsp_ready;
  assign accept = gnt_any & ~stall & ~rst;
  assign sel_x  = bus.req_x[int'(gnt_idx)*XW +: XW];

  assign bus.req_ready = (rst || stall) ? '0 : grant;
  assign bus.rsp_valid = s3_vld;
  assign bus.rsp_y     = s3_y;
  assign bus.rsp_id    = s3_id;
  assign bus.occupancy = {1'b0, s1_vld} + {1'b0, s2_vld} + {1'b0, s3_vld};

  // qhat underestimates floor(x/Q) by at most 2, so t < 3Q and two corrections suffice.
  assign qhat_d = QW'(({{(PW-XW){1'b0}}, s1_x} * {{(PW-RW){1'b0}}, R_C}) >> XW);
  assign qq     = {{(XW+1-QW){1'b0}}, s2_qhat} * Q_X;
  assign t0     = TW'({1'b0, s2_x} - qq);
  assign t1     = (t0 >= Q_T) ? t0 - Q_T : t0;
  assign y_d    = K'((t1 >= Q_T) ? t1 - Q_T : t1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= LAST_RST;
    end else if (accept) begin
      last <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_x    <= '0;
      s1_id   <= '0;
      s2_vld  <= 1'b0;
      s2_x    <= '0;
      s2_qhat <= '0;
      s2_id   <= '0;
      s3_vld  <= 1'b0;
      s3_y    <= '0;
      s3_id   <= '0;
    end else if (!stall) begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      if (accept) begin
        s1_x  <= sel_x;
        s1_id <= gnt_idx;
      end
      if (s1_vld) begin
        s2_x    <= s1_x;
        s2_qhat <= qhat_d;
        s2_id   <= s1_id;
      end
      if (s2_vld) begin
        s3_y  <= y_d;
        s3_id <= s2_id;
      end
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_residue_range: assert property (@(posedge clk) disable iff (rst)
    s3_vld |-> ({2'b00, s3_y} < Q_T));
  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    stall |=> (s3_vld && $stable(s3_y) && $stable(s3_id)));
endmodule

// File: tb/tb_modred_sched.sv
// Directed and constrained-random bench for modred_sched with Q=12289, N_REQ=4.
module tb_modred_sched;
  localparam int Q  = 12289;
  localparam int N  = 4;
  localparam int K  = 14;
  localparam int XW = 28;

  typedef struct {
    logic [K-1:0] y;
    logic [1:0]   id;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  modred_sched_if #(.Q(Q), .N_REQ(N)) bus();
  modred_sched #(.Q(Q), .N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [K-1:0] ref_mod(input logic [XW-1:0] x);
    return K'(longint'(x) % longint'(Q));
  endfunction

  function automatic logic [XW-1:0] pick_x();
    int unsigned k = $urandom_range(1, 21843);
    case ($urandom_range(0, 4))
      0:       return 28'hfffffff;
      1:       return 28'(k * Q);
      2:       return 28'(k * Q - 1);
      default: return 28'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    repeat (2) step();
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b, required 0", bus.rsp_valid); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d, required 0", bus.occupancy); end
    checks++; if (bus.rsp_y !== 14'd0) begin errors++; $display("FAIL reset_rsp_y: got %0d, required 0", bus.rsp_y); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d, required 0", bus.rsp_id); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b, required 0000", bus.req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b, required 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_single();
    logic [1:0] occ_exp [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic       rv_exp  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bus.req_valid = 4'b0001;
    bus.req_x[0 +: XW] = 28'd150994944;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b, required 0001", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.occupancy !== occ_exp[c]) begin errors++; $display("FAIL single_occ[%0d]: got %0d, required %0d", c, bus.occupancy, occ_exp[c]); end
      checks++; if (bus.rsp_valid !== rv_exp[c]) begin errors++; $display("FAIL single_rsp_valid[%0d]: got %0b, required %0b", c, bus.rsp_valid, rv_exp[c]); end
      if (c == 2) begin
        checks++; if (bus.rsp_y !== 14'd1 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp: got y=%0d id=%0d, required y=1 id=0", bus.rsp_y, bus.rsp_id); end
      end
      step();
    end
  endtask

  task automatic test_boundary();
    logic [XW-1:0] xs [4] = '{28'd0, 28'd12289, 28'd151019521, 28'd268435455};
    logic [K-1:0]  ys [4] = '{14'd0, 14'd0, 14'd0, 14'd6828};
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc < 4) begin
        bus.req_valid = 4'b0100;
        bus.req_x[2*XW +: XW] = xs[cyc];
      end else begin
        bus.req_valid = 4'b0000;
      end
      #1;
      if (cyc < 4) begin
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL boundary_grant[%0d]: got %b, required 0100", cyc, bus.req_ready); end
      end
      checks++; if (bus.rsp_valid !== (cyc >= 3 && cyc <= 6)) begin errors++; $display("FAIL boundary_rsp_valid[%0d]: got %0b, required %0b", cyc, bus.rsp_valid, (cyc >= 3 && cyc <= 6)); end
      if (cyc >= 3 && cyc <= 6) begin
        checks++; if (bus.rsp_y !== ys[cyc-3] || bus.rsp_id !== 2'd2) begin errors++; $display("FAIL boundary_rsp[%0d]: got y=%0d id=%0d, required y=%0d id=2", cyc-3, bus.rsp_y, bus.rsp_id, ys[cyc-3]); end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [XW-1:0] xv [4];
    rsp_t e;
    int nrsp = 0;
    pulse_reset();
    for (int i = 0; i < N; i++) xv[i] = pick_x();
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int i = 0; i < N; i++) bus.req_x[i*XW +: XW] = xv[i];
      bus.req_valid = (cyc < 16) ? 4'b1111 : 4'b0000;
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rr_rsp_extra: got y=%0d id=%0d, required no response", bus.rsp_y, bus.rsp_id); end
        else begin
          e = exp_q.pop_front();
          if (bus.rsp_y !== e.y || bus.rsp_id !== e.id) begin errors++; $display("FAIL rr_rsp: got y=%0d id=%0d, required y=%0d id=%0d", bus.rsp_y, bus.rsp_id, e.y, e.id); end
        end
      end
      if (cyc < 16) begin
        checks++; if (bus.req_ready !== 4'(1 << (cyc % 4))) begin errors++; $display("FAIL rr_grant[%0d]: got %b, required %b", cyc, bus.req_ready, 4'(1 << (cyc % 4))); end
        exp_q.push_back('{ref_mod(xv[cyc % 4]), 2'(cyc % 4)});
        xv[cyc % 4] = pick_x();
      end
      step();
    end
    checks++; if (nrsp !== 16) begin errors++; $display("FAIL rr_rsp_count: got %0d, required 16", nrsp); end
  endtask

  task automatic test_backpressure();
    logic [XW-1:0] xv [4] = '{28'd1000, 28'd150994944, 28'd268435455, 28'd24578};
    rsp_t e;
    int nrsp = 0;
    for (int i = 0; i < N; i++) bus.req_x[i*XW +: XW] = xv[i];
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.req_valid = (cyc < 8) ? 4'b1111 : 4'b0000;
      bus.rsp_ready = !(cyc >= 3 && cyc < 8);
      #1;
      if (cyc < 3) begin
        checks++; if (bus.req_ready !== 4'(1 << cyc)) begin errors++; $display("FAIL bp_grant[%0d]: got %b, required %b", cyc, bus.req_ready, 4'(1 << cyc)); end
        exp_q.push_back('{ref_mod(xv[cyc]), 2'(cyc)});
      end else if (cyc < 8) begin
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b, required 0000", cyc, bus.req_ready); end
        checks++; if (bus.occupancy !== 2'd3) begin errors++; $display("FAIL bp_occ[%0d]: got %0d, required 3", cyc, bus.occupancy); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== exp_q[0].y || bus.rsp_id !== exp_q[0].id) begin errors++; $display("FAIL bp_frozen[%0d]: got v=%0b y=%0d id=%0d, required v=1 y=%0d id=%0d", cyc, bus.rsp_valid, bus.rsp_y, bus.rsp_id, exp_q[0].y, exp_q[0].id); end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_rsp_extra: got y=%0d id=%0d, required no response", bus.rsp_y, bus.rsp_id); end
        else begin
          e = exp_q.pop_front();
          if (bus.rsp_y !== e.y || bus.rsp_id !== e.id) begin errors++; $display("FAIL bp_rsp: got y=%0d id=%0d, required y=%0d id=%0d", bus.rsp_y, bus.rsp_id, e.y, e.id); end
        end
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    checks++; if (nrsp !== 3) begin errors++; $display("FAIL bp_rsp_count: got %0d, required 3", nrsp); end
  endtask

  task automatic test_sparse();
    logic [3:0] vld  [6] = '{4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b1010, 4'b1010};
    logic [3:0] gnt  [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
    logic [1:0] gid  [6] = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd3, 2'd1};
    logic [XW-1:0] xv [6] = '{28'd5, 28'd12290, 28'd36866, 28'd200000000, 28'd12288, 28'd99999999};
    rsp_t e;
    int nrsp = 0;
    pulse_reset();
    for (int cyc = 0; cyc < 11; cyc++) begin
      bus.req_valid = (cyc < 6) ? vld[cyc] : 4'b0000;
      if (cyc < 6) bus.req_x[int'(gid[cyc])*XW +: XW] = xv[cyc];
      #1;
      if (cyc < 6) begin
        checks++; if (bus.req_ready !== gnt[cyc]) begin errors++; $display("FAIL sparse_grant[%0d]: got %b, required %b", cyc, bus.req_ready, gnt[cyc]); end
        exp_q.push_back('{ref_mod(xv[cyc]), gid[cyc]});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sparse_rsp_extra: got y=%0d id=%0d, required no response", bus.rsp_y, bus.rsp_id); end
        else begin
          e = exp_q.pop_front();
          if (bus.rsp_y !== e.y || bus.rsp_id !== e.id) begin errors++; $display("FAIL sparse_rsp: got y=%0d id=%0d, required y=%0d id=%0d", bus.rsp_y, bus.rsp_id, e.y, e.id); end
        end
      end
      step();
    end
    checks++; if (nrsp !== 6) begin errors++; $display("FAIL sparse_rsp_count: got %0d, required 6", nrsp); end
  endtask

  task automatic test_reset_midflight();
    for (int cyc = 0; cyc < 3; cyc++) begin
      bus.req_valid = 4'b0100;
      bus.req_x[2*XW +: XW] = 28'(1000 + cyc);
      #1;
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant[%0d]: got %b, required 0100", cyc, bus.req_ready); end
      step();
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.occupancy !== 2'd3 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got occ=%0d v=%0b, required occ=3 v=1", bus.occupancy, bus.rsp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL mid_reset_now: got v=%0b occ=%0d, required v=0 occ=0", bus.rsp_valid, bus.occupancy); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b, required 0000", bus.req_ready); end
    step();
    rst = 1'b0;
    bus.req_valid = 4'b1010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant: got %b, required 0010", bus.req_ready); end
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got v=%0b, required 0", c, bus.rsp_valid); end
    end
    exp_q.delete();
    step();
  endtask

  task automatic test_random();
    logic [XW-1:0] xv [4];
    logic [3:0]    vmask = 4'b0000;
    logic [3:0]    exp_rdy;
    int            m_last = 3;
    int            g;
    logic          stall;
    rsp_t          e;
    pulse_reset();
    for (int cyc = 0; cyc < 1600; cyc++) begin
      if (cyc < 1500) begin
        for (int i = 0; i < N; i++) begin
          if (!vmask[i] && $urandom_range(0, 2) != 0) begin
            vmask[i] = 1'b1;
            xv[i]    = pick_x();
          end
        end
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.rsp_ready = 1'b1;
      end
      for (int i = 0; i < N; i++) bus.req_x[i*XW +: XW] = xv[i];
      bus.req_valid = vmask;
      #1;
      stall = bus.rsp_valid && !bus.rsp_ready;
      g = -1;
      for (int off = 1; off <= N; off++) begin
        if (g < 0 && vmask[(m_last + off) % N]) g = (m_last + off) % N;
      end
      exp_rdy = (stall || g < 0) ? 4'b0000 : 4'(1 << g);
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rand_grant[%0d]: got %b, required %b", cyc, bus.req_ready, exp_rdy); end
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_rsp_extra: got y=%0d id=%0d, required no response", bus.rsp_y, bus.rsp_id); end
        else begin
          e = exp_q.pop_front();
          if (bus.rsp_y !== e.y || bus.rsp_id !== e.id) begin errors++; $display("FAIL rand_rsp: got y=%0d id=%0d, required y=%0d id=%0d", bus.rsp_y, bus.rsp_id, e.y, e.id); end
        end
      end
      if (exp_rdy != 4'b0000) begin
        exp_q.push_back('{ref_mod(xv[g]), 2'(g)});
        m_last   = g;
        vmask[g] = 1'b0;
      end
      step();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
